// File: rtl/execute_unit.sv
// execute_unit: execute/writeback stage with ALU, branch resolution, PSR and a single write port.
// Define EXEC_BARREL_SHIFT_EN for single-cycle ROT/SHF; the default build shifts one bit per cycle.
module execute_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               opcode,
    input  logic [3:0]               cc,
    input  logic [DATA_WIDTH-1:0]    operand_one,
    input  logic [DATA_WIDTH-1:0]    operand_two,
    input  logic                     dest_type,
    input  logic [ADDRESS_WIDTH-1:0] dest_adrs,
    output logic                     w_en,
    output logic                     w_dest_type,
    output logic [ADDRESS_WIDTH-1:0] w_adrs,
    output logic [DATA_WIDTH-1:0]    w_data,
    output logic                     br_taken,
    output logic [ADDRESS_WIDTH-1:0] br_target,
    output logic [4:0]               psr,
    output logic                     halted
);
    localparam logic [3:0] OP_LD  = 4'd1, OP_STR = 4'd2, OP_BRA = 4'd3, OP_XOR = 4'd4, OP_ADD = 4'd5,
                           OP_ROT = 4'd6, OP_SHF = 4'd7, OP_HLT = 4'd8, OP_CMP = 4'd9;

    typedef enum logic [1:0] {IDLE, SHIFT, HALT} state_t;

    state_t                   r_state, w_next;
    logic                     w_wr, w_br, w_carry, w_wtype;
    logic [DATA_WIDTH-1:0]    w_res;
    logic [ADDRESS_WIDTH-1:0] w_wadrs;
    logic [5:0]               w_mag;
    logic [7:0]               w_conds;
    logic [DATA_WIDTH:0]      w_shift;

    // One shift/rotate step: returns {bit shifted out, new value}.
    function automatic logic [DATA_WIDTH:0] f_step(input logic [DATA_WIDTH-1:0] d, input logic left, input logic rot);
        return left ? {d[DATA_WIDTH-1], d[DATA_WIDTH-2:0], rot & d[DATA_WIDTH-1]}
                    : {d[0], rot & d[0], d[DATA_WIDTH-1:1]};
    endfunction

    assign w_mag    = operand_two[5] ? -operand_two[5:0] : operand_two[5:0];
    assign w_conds  = {~psr[1], ~psr[4], psr[0], psr[1], psr[4], psr[2], psr[3], 1'b1};
    assign in_ready = r_state == IDLE;
    assign halted   = r_state == HALT;

`ifdef EXEC_BARREL_SHIFT_EN
    // Unrolled chain of the same one-bit step keeps results identical to the iterative build.
    always_comb begin
        w_shift = {psr[4], operand_two};
        for (int i = 0; i < 32; i++)
            if (i < int'(w_mag)) w_shift = f_step(w_shift[DATA_WIDTH-1:0], ~operand_two[5], opcode == OP_ROT);
    end
`else
    logic                     w_load;
    logic [DATA_WIDTH-1:0]    r_data;
    logic [5:0]               r_cnt;
    logic                     r_left, r_rot, r_dtype;
    logic [ADDRESS_WIDTH-1:0] r_adrs;

    assign w_shift = f_step(r_data, r_left, r_rot);
    assign w_load  = r_state == IDLE && in_valid && (opcode == OP_ROT || opcode == OP_SHF) && w_mag != 6'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
            r_rot   <= 1'b0;
            r_dtype <= 1'b0;
            r_adrs  <= '0;
        end else if (w_load) begin
            r_data  <= operand_two;
            r_cnt   <= w_mag;
            r_left  <= ~operand_two[5];
            r_rot   <= opcode == OP_ROT;
            r_dtype <= dest_type;
            r_adrs  <= dest_adrs;
        end else if (r_state == SHIFT) begin
            r_data <= w_shift[DATA_WIDTH-1:0];
            r_cnt  <= r_cnt - 6'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_wr    = 1'b0;
        w_br    = 1'b0;
        w_res   = operand_two;
        w_carry = psr[4];
        w_wtype = dest_type;
        w_wadrs = dest_adrs;
        case (r_state)
            IDLE: if (in_valid) begin
                case (opcode)
                    OP_LD, OP_STR: w_wr = 1'b1;
                    OP_XOR: begin
                        w_wr  = 1'b1;
                        w_res = operand_one ^ operand_two;
                    end
                    OP_ADD: begin
                        w_wr               = 1'b1;
                        {w_carry, w_res}   = {1'b0, operand_one} + {1'b0, operand_two};
                    end
                    OP_CMP: begin
                        w_wr  = 1'b1;
                        w_res = ~operand_two;
                    end
                    OP_BRA: w_br = ~cc[3] & w_conds[cc[2:0]];
                    OP_HLT: w_next = HALT;
                    OP_ROT, OP_SHF: begin
`ifdef EXEC_BARREL_SHIFT_EN
                        w_wr  = 1'b1;
                        w_res = w_shift[DATA_WIDTH-1:0];
                        if (opcode == OP_SHF) w_carry = w_shift[DATA_WIDTH];
`else
                        if (w_mag == 6'd0) w_wr = 1'b1;
                        else               w_next = SHIFT;
`endif
                    end
                    default: ;
                endcase
            end
`ifndef EXEC_BARREL_SHIFT_EN
            SHIFT: if (r_cnt == 6'd1) begin
                w_next  = IDLE;
                w_wr    = 1'b1;
                w_res   = w_shift[DATA_WIDTH-1:0];
                w_wtype = r_dtype;
                w_wadrs = r_adrs;
                if (!r_rot) w_carry = w_shift[DATA_WIDTH];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en        <= 1'b0;
            w_dest_type <= 1'b0;
            w_adrs      <= '0;
            w_data      <= '0;
            br_taken    <= 1'b0;
            br_target   <= '0;
            psr         <= '0;
        end else begin
            w_en     <= w_wr;
            br_taken <= w_br;
            if (w_br) br_target <= operand_one[ADDRESS_WIDTH-1:0];
            if (w_wr) begin
                w_dest_type <= w_wtype;
                w_adrs      <= w_wadrs;
                w_data      <= w_res;
                psr         <= {w_carry, ^w_res, ~w_res[0], w_res[DATA_WIDTH-1], w_res == '0};
            end
        end
    end
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed and randomized checks of execute_unit against a behavioural model.
`timescale 1ns/1ps
module tb_execute_unit;
    localparam int DW = 32, AW = 12;
`ifdef EXEC_BARREL_SHIFT_EN
    localparam bit BARREL = 1'b1;
    localparam int L32 = 0;
`else
    localparam bit BARREL = 1'b0;
    localparam int L32 = 32;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, dest_type = 1'b0;
    logic [3:0]    opcode = '0, cc = '0;
    logic [DW-1:0] operand_one = '0, operand_two = '0;
    logic [AW-1:0] dest_adrs = '0;
    logic          in_ready, w_en, w_dest_type, br_taken, halted;
    logic [AW-1:0] w_adrs, br_target;
    logic [DW-1:0] w_data;
    logic [4:0]    psr;
    int            total = 0, bad = 0;
    bit            chk_on = 1'b0;

    execute_unit #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .cc(cc),
        .operand_one(operand_one), .operand_two(operand_two), .dest_type(dest_type), .dest_adrs(dest_adrs),
        .w_en(w_en), .w_dest_type(w_dest_type), .w_adrs(w_adrs), .w_data(w_data),
        .br_taken(br_taken), .br_target(br_target), .psr(psr), .halted(halted)
    );

    always #5 clk = ~clk;

    // Expected architectural outputs, advanced once per clock edge
    logic          e_wen = 0, e_br = 0, e_halt = 0, e_dt = 0;
    logic [AW-1:0] e_adrs = '0, e_tgt = '0;
    logic [DW-1:0] e_data = '0;
    logic [4:0]    e_psr = '0;
    int            busy = 0;
    logic [DW-1:0] p_res;
    logic          p_c, p_dt;
    logic [AW-1:0] p_adrs;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mwrite(input logic [DW-1:0] r, input logic c, input logic dt, input logic [AW-1:0] a);
        e_wen  = 1'b1;
        e_data = r;
        e_dt   = dt;
        e_adrs = a;
        e_psr  = {c, 1'($countones(r) % 2), ~r[0], r[DW-1], r == '0};
    endtask

    // Returns {carry, result}; counts of 0 leave both value and carry untouched.
    function automatic logic [DW:0] mshift(input logic [DW-1:0] x, input int n, input bit rot, input bit right, input logic c);
        logic [2*DW-1:0] t;
        if (n == 0) return {c, x};
        if (rot) begin
            t = right ? ({x, x} >> (n % DW)) : ({x, x} << (n % DW));
            return {c, right ? t[DW-1:0] : t[2*DW-1:DW]};
        end
        t = right ? ({x, {DW{1'b0}}} >> n) : ({{DW{1'b0}}, x} << n);
        return right ? {t[DW-1], t[2*DW-1:DW]} : {t[DW], t[DW-1:0]};
    endfunction

    function automatic bit taken(input logic [3:0] c, input logic [4:0] p);
        logic carry, parity, even, neg, zero;
        {carry, parity, even, neg, zero} = p;
        case (c)
            4'd0: return 1'b1;
            4'd1: return parity;
            4'd2: return even;
            4'd3: return carry;
            4'd4: return neg;
            4'd5: return zero;
            4'd6: return ~carry;
            4'd7: return ~neg;
            default: return 1'b0;
        endcase
    endfunction

    task automatic accept();
        int sc, n;
        logic [DW:0] s;
        case (opcode)
            4'd1, 4'd2: mwrite(operand_two, e_psr[4], dest_type, dest_adrs);
            4'd3: if (taken(cc, e_psr)) begin
                e_br  = 1'b1;
                e_tgt = operand_one[AW-1:0];
            end
            4'd4: mwrite(operand_one ^ operand_two, e_psr[4], dest_type, dest_adrs);
            4'd5: begin
                s = {1'b0, operand_one} + {1'b0, operand_two};
                mwrite(s[DW-1:0], s[DW], dest_type, dest_adrs);
            end
            4'd6, 4'd7: begin
                sc = $signed(operand_two[5:0]);
                n  = sc < 0 ? -sc : sc;
                s  = mshift(operand_two, n, opcode == 4'd6, sc < 0, e_psr[4]);
                if (opcode == 4'd6) s[DW] = e_psr[4];
                if (n == 0 || BARREL) mwrite(s[DW-1:0], s[DW], dest_type, dest_adrs);
                else begin
                    busy   = n;
                    p_res  = s[DW-1:0];
                    p_c    = s[DW];
                    p_dt   = dest_type;
                    p_adrs = dest_adrs;
                end
            end
            4'd8: e_halt = 1'b1;
            4'd9: mwrite(~operand_two, e_psr[4], dest_type, dest_adrs);
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {e_wen, e_br, e_halt, e_dt} = '0;
            e_adrs = '0;
            e_tgt  = '0;
            e_data = '0;
            e_psr  = '0;
            busy   = 0;
        end else begin
            e_wen = 1'b0;
            e_br  = 1'b0;
            if (!e_halt && busy == 0 && in_valid) accept();
            else if (busy > 0) begin
                busy--;
                if (busy == 0) mwrite(p_res, p_c, p_dt, p_adrs);
            end
        end
    end

    always @(negedge clk) if (rst_n && chk_on) begin
        chk("in_ready", in_ready, !e_halt && busy == 0);
        chk("halted", halted, e_halt);
        chk("w_en", w_en, e_wen);
        chk("w_data", w_data, e_data);
        chk("w_adrs", w_adrs, e_adrs);
        chk("w_dest_type", w_dest_type, e_dt);
        chk("psr", psr, e_psr);
        chk("br_taken", br_taken, e_br);
        chk("br_target", br_target, e_tgt);
    end

    task automatic send(input logic [3:0] op, input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic dt, input logic [AW-1:0] ad);
        in_valid    = 1'b1;
        opcode      = op;
        cc          = c;
        operand_one = a;
        operand_two = b;
        dest_type   = dt;
        dest_adrs   = ad;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst w_en", w_en, 0);
        chk("rst w_data", w_data, 0);
        chk("rst psr", psr, 0);
        chk("rst halted", halted, 0);
        chk("rst in_ready", in_ready, 1);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);
        send(4'd5, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b1, 12'h005);
        chk("add w_en", w_en, 1);
        chk("add w_data", w_data, 0);
        chk("add w_adrs", w_adrs, 12'h005);
        chk("add psr", psr, 5'b10101);
        send(4'd5, 4'd0, 32'd3, 32'd4, 1'b1, 12'h006);
        send(4'd3, 4'b0101, 32'h0AB, 32'd0, 1'b0, 12'h000);
        chk("bra zero taken", br_taken, 0);
        send(4'd3, 4'b0001, 32'h0AB, 32'd0, 1'b0, 12'h000);
        chk("bra parity taken", br_taken, 1);
        chk("bra target", br_target, 12'h0AB);
        send(4'd7, 4'd0, 32'h8000_0001, 32'h0000_003F, 1'b1, 12'h010);
`ifndef EXEC_BARREL_SHIFT_EN
        chk("shf busy in_ready", in_ready, 0);
        chk("shf early w_en", w_en, 0);
        @(negedge clk);
`endif
        chk("shf w_en", w_en, 1);
        chk("shf w_data", w_data, 32'h0000_001F);
        chk("shf psr", psr, 5'b11000);
        chk("shf in_ready", in_ready, 1);
        send(4'd6, 4'd0, 32'd0, 32'h1234_5604, 1'b0, 12'h020);
`ifndef EXEC_BARREL_SHIFT_EN
        for (int i = 0; i < 4; i++) begin
            chk("rot busy in_ready", in_ready, 0);
            chk("rot early w_en", w_en, 0);
            @(negedge clk);
        end
`endif
        chk("rot w_en", w_en, 1);
        chk("rot w_data", w_data, 32'h2345_6041);
        chk("rot psr", psr, 5'b10000);
        send(4'd6, 4'd0, 32'd0, 32'h8000_0040, 1'b1, 12'h021);
        chk("rot0 w_data", w_data, 32'h8000_0040);
        chk("rot0 psr", psr, 5'b10110);
        send(4'd7, 4'd0, 32'd0, 32'hFFFF_FFE0, 1'b1, 12'h022);
        repeat (L32) @(negedge clk);
        chk("shf-32 w_en", w_en, 1);
        chk("shf-32 w_data", w_data, 0);
        chk("shf-32 psr", psr, 5'b10101);
        repeat (3000) begin
            in_valid    = $urandom_range(0, 9) < 7;
            opcode      = 4'($urandom_range(0, 15));
            if (opcode == 4'd8) opcode = 4'd0;
            cc          = 4'($urandom_range(0, 9));
            operand_one = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom;
            operand_two = $urandom;
            if ($urandom_range(0, 3) == 0) operand_two[5:0] = 6'($urandom_range(0, 2)) | (operand_two[5] ? 6'h3C : 6'h00);
            dest_type   = 1'($urandom);
            dest_adrs   = 12'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        send(4'd4, 4'd0, 32'h1, 32'h10, 1'b1, 12'h3FF);
        send(4'd3, 4'd0, 32'h0CD, 32'd0, 1'b0, 12'h000);
        send(4'd7, 4'd0, 32'd0, 32'h0000_0014, 1'b1, 12'h033);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async w_en", w_en, 0);
        chk("async w_data", w_data, 0);
        chk("async w_adrs", w_adrs, 0);
        chk("async w_dest_type", w_dest_type, 0);
        chk("async psr", psr, 0);
        chk("async br_taken", br_taken, 0);
        chk("async br_target", br_target, 0);
        chk("async halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        send(4'd8, 4'd0, 32'd0, 32'd0, 1'b0, 12'h000);
        in_valid    = 1'b1;
        opcode      = 4'd5;
        operand_one = 32'd7;
        operand_two = 32'd9;
        repeat (5) begin
            chk("hlt halted", halted, 1);
            chk("hlt in_ready", in_ready, 0);
            chk("hlt w_en", w_en, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        #1;
        chk("post-hlt halted", halted, 0);
        chk("post-hlt psr", psr, 0);
        chk("post-hlt in_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
